// File: rtl/gcd_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_sequencer
//   Iterative subtract/swap GCD engine. Owns the A/B operand registers and
//   produces the Control/FlagZ pair consumed by the downstream swap stage.
//   One RUN step per clock: terminate on B==0, swap when A<B, otherwise A-=B.
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : load request, honoured only in IDLE
//   a_in     : operand A, captured with an accepted start
//   b_in     : operand B, captured with an accepted start
//   busy     : operation in progress
//   done     : one-cycle completion pulse
//   result   : GCD of the last completed operation (held)
//   steps    : RUN cycles used by the last operation (held, saturating)
//   Control  : 0 = swap this cycle, 1 = keep order (combinational)
//   FlagZ    : B register is zero (combinational)
//   ra_q     : current A register
//   rb_q     : current B register
// -----------------------------------------------------------------------------
module gcd_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic [2*W-1:0] steps,
  output logic           Control,
  output logic           FlagZ,
  output logic [W-1:0]   ra_q,
  output logic [W-1:0]   rb_q
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_result;
  logic [2*W-1:0] r_steps;

  logic [W-1:0]   w_a_nxt;
  logic [W-1:0]   w_b_nxt;
  logic [2*W-1:0] w_cnt_nxt;
  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic [W-1:0]   w_result_nxt;
  logic [2*W-1:0] w_steps_nxt;

  logic           w_b_zero;
  logic           w_a_lt_b;

  // Step counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [2*W-1:0] sat_inc(input logic [2*W-1:0] v);
    logic [2*W-1:0] r;
    if (v == {(2*W){1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(2*W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  assign w_b_zero = (r_b == {W{1'b0}});
  assign w_a_lt_b = (r_a < r_b);

  // Swap-stage controls: a swap is requested only by a live RUN step with A<B.
  assign FlagZ   = w_b_zero;
  assign Control = ~((r_state == ST_RUN) & ~w_b_zero & w_a_lt_b);

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign steps  = r_steps;
  assign ra_q   = r_a;
  assign rb_q   = r_b;

  // Next-state and datapath update for one GCD step.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_steps_nxt  = r_steps;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_nxt     = a_in;
          w_b_nxt     = b_in;
          w_cnt_nxt   = {(2*W){1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = sat_inc(r_cnt);
        if (w_b_zero) begin
          // Terminal step: the step being executed now is counted too.
          w_result_nxt = r_a;
          w_steps_nxt  = sat_inc(r_cnt);
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else if (w_a_lt_b) begin
          w_a_nxt = r_b;
          w_b_nxt = r_a;
        end else begin
          // A >= B here, so the subtraction cannot underflow.
          w_a_nxt = r_a - r_b;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_cnt    <= {(2*W){1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {W{1'b0}};
      r_steps  <= {(2*W){1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_steps  <= w_steps_nxt;
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
module tb_gcd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic [15:0] steps;
  logic        Control;
  logic        FlagZ;
  logic [7:0]  ra_q;
  logic [7:0]  rb_q;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-RUN-cycle view built from the algorithm's rules.
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic       exp_c[$];
  logic       exp_z[$];

  gcd_sequencer #(.W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .steps   (steps),
    .Control (Control),
    .FlagZ   (FlagZ),
    .ra_q    (ra_q),
    .rb_q    (rb_q)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: list the (A,B) pair seen in each RUN cycle, until B==0 ends it.
  task automatic build_model(input logic [7:0] a0, input logic [7:0] b0,
                             output logic [7:0] res, output int n);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    a = a0;
    b = b0;
    exp_a.delete();
    exp_b.delete();
    exp_c.delete();
    exp_z.delete();
    while (1) begin
      exp_a.push_back(a);
      exp_b.push_back(b);
      exp_z.push_back(b == 8'd0);
      exp_c.push_back(!((b != 8'd0) && (a < b)));
      if (b == 8'd0) break;
      if (a < b) begin
        t = a; a = b; b = t;
      end else begin
        a = a - b;
      end
    end
    res = a;
    n = exp_a.size();
  endtask

  // Run one operation; nowait=1 issues start in the current (done) cycle.
  // inj>0 drives a stray start(9,3) in that RUN cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit nowait,
                       input int inj, output logic [7:0] o_res, output logic [15:0] o_steps);
    logic [7:0] m_res;
    int m_n;
    int cyc;
    bit seen;
    build_model(a, b, m_res, m_n);
    if (!nowait) @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    check_val("done_low_first_run", done, 1'b0);
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 1000) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check_val("busy_run", busy, 1'b1);
      if (cyc - 1 < m_n) begin
        check_val("ra_q", ra_q, exp_a[cyc-1]);
        check_val("rb_q", rb_q, exp_b[cyc-1]);
        check_val("Control", Control, exp_c[cyc-1]);
        check_val("FlagZ", FlagZ, exp_z[cyc-1]);
      end else begin
        check_val("run_too_long", cyc, m_n);
      end
      if (cyc == inj) begin
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_val("done_seen", seen, 1'b1);
    check_val("result", result, m_res);
    check_val("steps", steps, m_n);
    check_val("latency", cyc, m_n + 1);
    check_val("busy_done", busy, 1'b0);
    check_val("Control_idle", Control, 1'b1);
    o_res   = result;
    o_steps = steps;
  endtask

  initial begin
    logic [7:0]  r;
    logic [15:0] s;
    logic [7:0]  ra;
    logic [7:0]  rb;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'd0;
    b_in  = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_result", result, 8'd0);
    check_val("rst_steps", steps, 16'd0);
    check_val("rst_FlagZ", FlagZ, 1'b1);
    check_val("rst_Control", Control, 1'b1);
    check_val("rst_ra", ra_q, 8'd0);
    check_val("rst_rb", rb_q, 8'd0);

    // Directed cases with hand-derived answers.
    do_op(8'd12, 8'd8, 1'b0, 0, r, s);
    check_val("g12_8_res", r, 8'd4);
    check_val("g12_8_steps", s, 16'd6);
    @(negedge clk);
    check_val("done_single_pulse", done, 1'b0);
    check_val("result_held", result, 8'd4);

    do_op(8'd7, 8'd0, 1'b0, 0, r, s);
    check_val("g7_0_res", r, 8'd7);
    check_val("g7_0_steps", s, 16'd1);
    do_op(8'd0, 8'd5, 1'b0, 0, r, s);
    check_val("g0_5_res", r, 8'd5);
    check_val("g0_5_steps", s, 16'd2);
    do_op(8'd0, 8'd0, 1'b0, 0, r, s);
    check_val("g0_0_res", r, 8'd0);
    check_val("g0_0_steps", s, 16'd1);
    do_op(8'd255, 8'd1, 1'b0, 50, r, s);
    check_val("g255_1_res", r, 8'd1);
    check_val("g255_1_steps", s, 16'd257);

    // Reset in the middle of gcd(200,3).
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'd200;
    b_in  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_result", result, 8'd0);
    check_val("mid_rst_steps", steps, 16'd0);
    check_val("mid_rst_FlagZ", FlagZ, 1'b1);
    check_val("mid_rst_done", done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("post_rst_no_done", done, 1'b0);
    end
    do_op(8'd48, 8'd18, 1'b0, 0, r, s);
    check_val("g48_18_res", r, 8'd6);

    // Back-to-back: second start issued in the done cycle of the first.
    do_op(8'd10, 8'd4, 1'b0, 0, r, s);
    check_val("b2b_first_res", r, 8'd2);
    do_op(8'd21, 8'd14, 1'b1, 0, r, s);
    check_val("b2b_second_res", r, 8'd7);

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, 1'($urandom_range(0, 1)), 0, r, s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
